// File: rtl/isp_seq_pkg.sv
// isp_seq_pkg: state/cause types and shared constants for the MSS
// fabric power-up and ISP sequencer.
package isp_seq_pkg;

   typedef enum logic [2:0] {
      ST_RESET      = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_ASSERT_FAB = 3'd2,
      ST_WAIT_READY = 3'd3,
      ST_RUN        = 3'd4,
      ST_ISP_HOLD   = 3'd5,
      ST_FAULT      = 3'd6
   } seq_state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'b00,
      CAUSE_TIMEOUT = 2'b01,
      CAUSE_LOCK    = 2'b10,
      CAUSE_ISP     = 2'b11
   } fault_cause_t;

   localparam int SYNC_STAGES = 2;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/isp_seq_sync_debounce.sv
// isp_seq_sync_debounce: 2-flop synchroniser with an optional
// stable-count debounce (DEBOUNCE_CYCLES=0 gives a plain synchroniser).
module isp_seq_sync_debounce
   import isp_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 0
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sync <= '0;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
   end

   assign w_s = r_sync[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_nodb
         assign o_q = w_s;
      end else begin : g_db
         localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
         logic [CW-1:0] r_cnt;
         logic          r_q;

         // any return to the held level restarts the stability count
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_cnt <= '0;
               r_q   <= 1'b0;
            end else if (w_s == r_q) begin
               r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               r_q   <= w_s;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         assign o_q = r_q;
      end
   endgenerate

endmodule

// File: rtl/isp_fabric_sequencer.sv
// isp_fabric_sequencer: MSS fabric power-up / ISP sequencer.
// Define ISP_SEQ_CAUSE_EN to add the sticky FAULT_CAUSE output.
module isp_fabric_sequencer
   import isp_seq_pkg::*;
#(
   parameter int LOCK_FILTER_CYCLES   = 16,
   parameter int RESET_HOLD_CYCLES    = 64,
   parameter int READY_TIMEOUT_CYCLES = 1048576,
   parameter int ISP_DEBOUNCE_CYCLES  = 8,
   parameter int MAX_RETRIES          = 3
)(
   input  logic       CLK_BASE,
   input  logic       POWER_ON_RESET_N,
   input  logic       FAB_CCC_LOCK,
   input  logic       MSS_READY,
   input  logic       INIT_DONE,
   input  logic       GPIO_3_M2F,
   input  logic       SW_RESTART_REQ,
   output logic       FAB_RESET_N,
   output logic       USER_RESET_N,
   output logic       USER_CLK_EN,
   output logic [2:0] SEQ_STATE,
   output logic [1:0] RETRY_COUNT,
`ifdef ISP_SEQ_CAUSE_EN
   output logic [1:0] FAULT_CAUSE,
`endif
   output logic       ERROR
);

   localparam int CNT_MAX = max3(LOCK_FILTER_CYCLES, RESET_HOLD_CYCLES,
                                 READY_TIMEOUT_CYCLES);
   localparam int CW = $clog2(CNT_MAX + 1);

   logic [SYNC_STAGES-1:0] r_rst_sync;
   seq_state_t             r_state;
   seq_state_t             w_next;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          w_cnt_next;
   logic [1:0]             r_retry;
   logic [1:0]             w_retry_next;
   logic                   r_fab_rst_n;
   logic                   r_user_en;
   logic                   r_err;
   logic                   w_lock;
   logic                   w_ready;
   logic                   w_init;
   logic                   w_isp;
   logic                   w_rst_rel;
   logic                   w_lock_lost;

   always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
      if (!POWER_ON_RESET_N) r_rst_sync <= '0;
      else r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
   end

   assign w_rst_rel = r_rst_sync[SYNC_STAGES-1];

   isp_seq_sync_debounce #(.DEBOUNCE_CYCLES(0)) u_sync_lock (
      .i_clk(CLK_BASE), .i_rst_n(POWER_ON_RESET_N),
      .i_d(FAB_CCC_LOCK), .o_q(w_lock));

   isp_seq_sync_debounce #(.DEBOUNCE_CYCLES(0)) u_sync_ready (
      .i_clk(CLK_BASE), .i_rst_n(POWER_ON_RESET_N),
      .i_d(MSS_READY), .o_q(w_ready));

   isp_seq_sync_debounce #(.DEBOUNCE_CYCLES(0)) u_sync_init (
      .i_clk(CLK_BASE), .i_rst_n(POWER_ON_RESET_N),
      .i_d(INIT_DONE), .o_q(w_init));

   isp_seq_sync_debounce #(.DEBOUNCE_CYCLES(ISP_DEBOUNCE_CYCLES)) u_sync_isp (
      .i_clk(CLK_BASE), .i_rst_n(POWER_ON_RESET_N),
      .i_d(GPIO_3_M2F), .o_q(w_isp));

   assign w_lock_lost = !w_lock &&
      (r_state inside {ST_ASSERT_FAB, ST_WAIT_READY, ST_RUN, ST_ISP_HOLD});

   // lock loss pre-empts every other transition from states 2..5
   always_comb begin
      w_next       = r_state;
      w_cnt_next   = r_cnt;
      w_retry_next = r_retry;
      if (w_lock_lost) begin
         w_next = ST_WAIT_LOCK;
      end else begin
         unique case (r_state)
            ST_RESET: begin
               if (w_rst_rel) w_next = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
               if (!w_lock) w_cnt_next = '0;
               else if (r_cnt == CW'(LOCK_FILTER_CYCLES - 1))
                  w_next = ST_ASSERT_FAB;
               else w_cnt_next = r_cnt + 1'b1;
            end
            ST_ASSERT_FAB: begin
               if (r_cnt == CW'(RESET_HOLD_CYCLES - 1))
                  w_next = ST_WAIT_READY;
               else w_cnt_next = r_cnt + 1'b1;
            end
            ST_WAIT_READY: begin
               if (w_ready && w_init) begin
                  w_next       = ST_RUN;
                  w_retry_next = '0;
               end else if (r_cnt == CW'(READY_TIMEOUT_CYCLES - 1)) begin
                  if (r_retry < 2'(MAX_RETRIES)) begin
                     w_retry_next = r_retry + 1'b1;
                     w_next       = ST_ASSERT_FAB;
                  end else begin
                     w_next = ST_FAULT;
                  end
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (!w_ready)   w_next = ST_WAIT_READY;
               else if (w_isp) w_next = ST_ISP_HOLD;
            end
            ST_ISP_HOLD: begin
               if (!w_isp) w_next = ST_ASSERT_FAB;
            end
            ST_FAULT: begin
               if (SW_RESTART_REQ) begin
                  w_next       = ST_WAIT_LOCK;
                  w_retry_next = '0;
               end
            end
            default: w_next = ST_RESET;
         endcase
      end
   end

   always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
      if (!POWER_ON_RESET_N) begin
         r_state     <= ST_RESET;
         r_cnt       <= '0;
         r_retry     <= '0;
         r_fab_rst_n <= 1'b0;
         r_user_en   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cnt       <= (w_next != r_state) ? '0 : w_cnt_next;
         r_retry     <= w_retry_next;
         r_fab_rst_n <= w_next inside {ST_WAIT_READY, ST_RUN, ST_ISP_HOLD};
         r_user_en   <= (r_state == ST_RUN) && (w_next == ST_RUN);
         r_err       <= (w_next == ST_FAULT);
      end
   end

`ifdef ISP_SEQ_CAUSE_EN
   fault_cause_t r_cause;

   always_ff @(posedge CLK_BASE or negedge POWER_ON_RESET_N) begin
      if (!POWER_ON_RESET_N)
         r_cause <= CAUSE_NONE;
      else if (r_state == ST_FAULT && SW_RESTART_REQ)
         r_cause <= CAUSE_NONE;
      else if (r_state == ST_WAIT_READY && w_next == ST_FAULT)
         r_cause <= CAUSE_TIMEOUT;
      else if (r_state == ST_RUN && w_lock_lost)
         r_cause <= CAUSE_LOCK;
      else if (r_state == ST_ISP_HOLD && w_next != ST_ISP_HOLD)
         r_cause <= CAUSE_ISP;
   end

   assign FAULT_CAUSE = r_cause;
`endif

   assign FAB_RESET_N  = r_fab_rst_n;
   assign USER_RESET_N = r_user_en;
   assign USER_CLK_EN  = r_user_en;
   assign SEQ_STATE    = r_state;
   assign RETRY_COUNT  = r_retry;
   assign ERROR        = r_err;

endmodule

// File: tb/tb_isp_fabric_sequencer.sv
// tb_isp_fabric_sequencer: directed bench with a state-transition
// scoreboard for isp_fabric_sequencer.
module tb_isp_fabric_sequencer;

   logic       CLK_BASE = 1'b0;
   logic       POWER_ON_RESET_N = 1'b1;
   logic       FAB_CCC_LOCK = 1'b0;
   logic       MSS_READY = 1'b0;
   logic       INIT_DONE = 1'b0;
   logic       GPIO_3_M2F = 1'b0;
   logic       SW_RESTART_REQ = 1'b0;
   logic       FAB_RESET_N;
   logic       USER_RESET_N;
   logic       USER_CLK_EN;
   logic [2:0] SEQ_STATE;
   logic [1:0] RETRY_COUNT;
   logic       ERROR;
`ifdef ISP_SEQ_CAUSE_EN
   logic [1:0] FAULT_CAUSE;
`endif

   int checks = 0;
   int errors = 0;
   logic [2:0] q_exp[$];
   logic [2:0] prev_st = 3'd0;

   isp_fabric_sequencer #(
      .LOCK_FILTER_CYCLES(4),
      .RESET_HOLD_CYCLES(8),
      .READY_TIMEOUT_CYCLES(32),
      .ISP_DEBOUNCE_CYCLES(3),
      .MAX_RETRIES(2)
   ) dut (
      .CLK_BASE(CLK_BASE),
      .POWER_ON_RESET_N(POWER_ON_RESET_N),
      .FAB_CCC_LOCK(FAB_CCC_LOCK),
      .MSS_READY(MSS_READY),
      .INIT_DONE(INIT_DONE),
      .GPIO_3_M2F(GPIO_3_M2F),
      .SW_RESTART_REQ(SW_RESTART_REQ),
      .FAB_RESET_N(FAB_RESET_N),
      .USER_RESET_N(USER_RESET_N),
      .USER_CLK_EN(USER_CLK_EN),
      .SEQ_STATE(SEQ_STATE),
      .RETRY_COUNT(RETRY_COUNT),
`ifdef ISP_SEQ_CAUSE_EN
      .FAULT_CAUSE(FAULT_CAUSE),
`endif
      .ERROR(ERROR)
   );

   always #5 CLK_BASE = ~CLK_BASE;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // every SEQ_STATE change must match the next queued expectation
   always @(negedge CLK_BASE) begin
      if (SEQ_STATE !== prev_st) begin
         if (q_exp.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_unexpected observed=%0d expected=none", SEQ_STATE);
         end else begin
            chk("sb_state", {29'd0, SEQ_STATE}, {29'd0, q_exp.pop_front()});
         end
         prev_st = SEQ_STATE;
      end
   end

   task automatic tick();
      @(posedge CLK_BASE);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int lim,
                             input string tag);
      int n;
      n = 0;
      while (SEQ_STATE !== s && n < lim) begin
         tick();
         n++;
      end
      chk(tag, {29'd0, SEQ_STATE}, {29'd0, s});
   endtask

   task automatic pulse_check(input logic [1:0] k);
      int n;
      int low_n;
      n = 0;
      low_n = 0;
      wait_state(3'd2, 80, "fab_enter");
      while (SEQ_STATE === 3'd2 && n < 40) begin
         if (FAB_RESET_N === 1'b0) low_n++;
         n++;
         tick();
      end
      chk("fab_low_len", low_n, 8);
      chk("fab_then_wait_ready", {29'd0, SEQ_STATE}, 3);
      chk("fab_released", {31'd0, FAB_RESET_N}, 1);
      chk("retry_count", {30'd0, RETRY_COUNT}, {30'd0, k});
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_fab"}, {31'd0, FAB_RESET_N}, 0);
      chk({tag, "_urst"}, {31'd0, USER_RESET_N}, 0);
      chk({tag, "_clken"}, {31'd0, USER_CLK_EN}, 0);
      chk({tag, "_state"}, {29'd0, SEQ_STATE}, 0);
      chk({tag, "_retry"}, {30'd0, RETRY_COUNT}, 0);
      chk({tag, "_error"}, {31'd0, ERROR}, 0);
   endtask

   initial begin
      logic [7:0] pat;
      pat = 8'b1111_0111;
      #1 POWER_ON_RESET_N = 1'b0;
      repeat (3) tick();
      chk_reset_outs("rst");

      // nominal bring-up
      q_exp.push_back(3'd1);
      q_exp.push_back(3'd2);
      q_exp.push_back(3'd3);
      q_exp.push_back(3'd4);
      FAB_CCC_LOCK = 1'b1;
      POWER_ON_RESET_N = 1'b1;
      pulse_check(2'd0);
      MSS_READY = 1'b1;
      INIT_DONE = 1'b1;
      wait_state(3'd4, 20, "run_entry");
      chk("urst_at_entry", {31'd0, USER_RESET_N}, 0);
      tick();
      chk("urst_after_entry", {31'd0, USER_RESET_N}, 1);
      chk("clken_after_entry", {31'd0, USER_CLK_EN}, 1);
      chk("run_retry", {30'd0, RETRY_COUNT}, 0);

      // restart request outside FAULT is ignored
      SW_RESTART_REQ = 1'b1;
      tick();
      SW_RESTART_REQ = 1'b0;
      repeat (3) tick();
      chk("sw_ignored_state", {29'd0, SEQ_STATE}, 4);
      chk("sw_ignored_error", {31'd0, ERROR}, 0);

      // short ISP glitch
      GPIO_3_M2F = 1'b1;
      repeat (2) tick();
      GPIO_3_M2F = 1'b0;
      repeat (10) tick();
      chk("isp_short_state", {29'd0, SEQ_STATE}, 4);
      chk("isp_short_clken", {31'd0, USER_CLK_EN}, 1);

      // real ISP window
      q_exp.push_back(3'd5);
      GPIO_3_M2F = 1'b1;
      repeat (6) tick();
      wait_state(3'd5, 4, "isp_hold");
      chk("isp_clken", {31'd0, USER_CLK_EN}, 0);
      chk("isp_urst", {31'd0, USER_RESET_N}, 0);
      chk("isp_fab", {31'd0, FAB_RESET_N}, 1);
      q_exp.push_back(3'd2);
      q_exp.push_back(3'd3);
      q_exp.push_back(3'd4);
      GPIO_3_M2F = 1'b0;
      wait_state(3'd2, 15, "isp_exit");
`ifdef ISP_SEQ_CAUSE_EN
      chk("cause_isp", {30'd0, FAULT_CAUSE}, 3);
`endif
      wait_state(3'd4, 30, "isp_rerun");
      tick();

      // lock loss and debounced ISP land on the same edge
      q_exp.push_back(3'd1);
      GPIO_3_M2F = 1'b1;
      repeat (3) tick();
      FAB_CCC_LOCK = 1'b0;
      wait_state(3'd1, 3, "prio_lock");
      GPIO_3_M2F = 1'b0;
      tick();
      chk("prio_clken", {31'd0, USER_CLK_EN}, 0);
      chk("prio_fab", {31'd0, FAB_RESET_N}, 0);
`ifdef ISP_SEQ_CAUSE_EN
      chk("cause_lock", {30'd0, FAULT_CAUSE}, 2);
`endif
      repeat (4) tick();

      // glitchy lock: 1,1,1,0,1,1,1,1
      q_exp.push_back(3'd2);
      q_exp.push_back(3'd3);
      q_exp.push_back(3'd4);
      for (int i = 0; i < 8; i++) begin
         FAB_CCC_LOCK = pat[i];
         tick();
         chk("glitch_hold", {29'd0, SEQ_STATE}, 1);
      end
      tick();
      chk("glitch_late", {29'd0, SEQ_STATE}, 1);
      tick();
      chk("glitch_accept", {29'd0, SEQ_STATE}, 2);
      wait_state(3'd4, 20, "glitch_run");

      // async reset while waiting for ready
      q_exp.push_back(3'd3);
      MSS_READY = 1'b0;
      wait_state(3'd3, 6, "ready_drop");
      repeat (5) tick();
      q_exp.push_back(3'd0);
      #3 POWER_ON_RESET_N = 1'b0;
      #2 chk_reset_outs("async_rst");
      repeat (2) tick();

      // ready never arrives: three reset pulses then FAULT
      q_exp.push_back(3'd1);
      q_exp.push_back(3'd2);
      q_exp.push_back(3'd3);
      q_exp.push_back(3'd2);
      q_exp.push_back(3'd3);
      q_exp.push_back(3'd2);
      q_exp.push_back(3'd3);
      q_exp.push_back(3'd6);
      FAB_CCC_LOCK = 1'b1;
      POWER_ON_RESET_N = 1'b1;
      pulse_check(2'd0);
      pulse_check(2'd1);
      pulse_check(2'd2);
      wait_state(3'd6, 60, "fault");
      chk("fault_error", {31'd0, ERROR}, 1);
      chk("fault_fab", {31'd0, FAB_RESET_N}, 0);
      chk("fault_retry", {30'd0, RETRY_COUNT}, 2);
      chk("fault_urst", {31'd0, USER_RESET_N}, 0);
`ifdef ISP_SEQ_CAUSE_EN
      chk("cause_timeout", {30'd0, FAULT_CAUSE}, 1);
`endif
      repeat (3) tick();
      chk("fault_sticky", {29'd0, SEQ_STATE}, 6);

      q_exp.push_back(3'd1);
      FAB_CCC_LOCK = 1'b0;
      SW_RESTART_REQ = 1'b1;
      tick();
      SW_RESTART_REQ = 1'b0;
      chk("restart_state", {29'd0, SEQ_STATE}, 1);
      chk("restart_error", {31'd0, ERROR}, 0);
      chk("restart_retry", {30'd0, RETRY_COUNT}, 0);
`ifdef ISP_SEQ_CAUSE_EN
      chk("cause_cleared", {30'd0, FAULT_CAUSE}, 0);
`endif
      repeat (5) tick();
      chk("sb_drained", q_exp.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/isp_fabric_sequencer.md
Name: isp_fabric_sequencer

Overview:
- Fabric-side power-up and ISP sequencer for the MSS subsystem.
- Drives the subsystem's FAB_RESET_N and qualifies CCC lock, MSS_READY and INIT_DONE before releasing user-logic reset and clock enable.
- Parks user logic safely while MSS firmware signals ISP-in-progress on GPIO_3_M2F, then re-sequences after programming.
- Sits in the top level beside the MSS subsystem; clocked from the fabric CCC GL0.

Parameters:
- LOCK_FILTER_CYCLES, 16: consecutive FAB_CCC_LOCK-high cycles required to accept lock.
- RESET_HOLD_CYCLES, 64: FAB_RESET_N low duration per sequence.
- READY_TIMEOUT_CYCLES, 1048576: maximum wait for MSS_READY & INIT_DONE.
- ISP_DEBOUNCE_CYCLES, 8: stable cycles for any GPIO_3_M2F level change.
- MAX_RETRIES, 3: ready-timeout retries before fault; 2-bit counter, saturating.

Ports:
- CLK_BASE  in  1  fabric clock (CCC GL0).
- POWER_ON_RESET_N  in  1  asynchronous active-low reset.
- FAB_CCC_LOCK  in  1  CCC lock; asynchronous.
- MSS_READY  in  1  MSS ready from reset controller; asynchronous.
- INIT_DONE  in  1  device init complete; asynchronous.
- GPIO_3_M2F  in  1  firmware ISP-active flag, 1 = programming in progress; asynchronous.
- SW_RESTART_REQ  in  1  single-cycle pulse; leaves FAULT.
- FAB_RESET_N  out  1  to subsystem FAB_RESET_N.
- USER_RESET_N  out  1  user-logic reset, active-low.
- USER_CLK_EN  out  1  user-logic clock enable.
- SEQ_STATE  out  3  current state encoding.
- RETRY_COUNT  out  2  ready-timeout retries used.
- ERROR  out  1  high in FAULT.

Behaviour:
- Clock and reset: one clock, CLK_BASE. Reset is POWER_ON_RESET_N, asynchronous assert, active-low. Deassertion is synchronised internally (2-flop) before the FSM leaves RESET.
- Input sync: the four status inputs pass through 2-flop synchronisers, adding 2 cycles of latency. All outputs are registered.
- Reset values: FAB_RESET_N=0, USER_RESET_N=0, USER_CLK_EN=0, SEQ_STATE=0, RETRY_COUNT=0, ERROR=0.
- State encodings: RESET=0, WAIT_LOCK=1, ASSERT_FAB=2, WAIT_READY=3, RUN=4, ISP_HOLD=5, FAULT=6.
- RESET: moves to WAIT_LOCK on the first cycle after synchronised reset release.
- WAIT_LOCK:
  - Filter counter increments while lock is high; any low cycle clears it.
  - At LOCK_FILTER_CYCLES, go to ASSERT_FAB.
- ASSERT_FAB:
  - FAB_RESET_N=0 for exactly RESET_HOLD_CYCLES, then go to WAIT_READY.
- WAIT_READY:
  - FAB_RESET_N=1; timeout counter starts at 0.
  - MSS_READY & INIT_DONE both high: go to RUN and clear RETRY_COUNT.
  - Timeout reached with RETRY_COUNT<MAX_RETRIES: increment RETRY_COUNT, go to ASSERT_FAB.
  - Timeout reached otherwise: go to FAULT.
- RUN:
  - USER_RESET_N=1 and USER_CLK_EN=1, both registered one cycle after entry.
  - MSS_READY low: go to WAIT_READY with a fresh timeout.
  - Debounced ISP flag high: go to ISP_HOLD.
- ISP_HOLD:
  - USER_CLK_EN=0 and USER_RESET_N=0; FAB_RESET_N stays 1 because the MSS must keep running.
  - Debounced flag low: go to ASSERT_FAB.
  - The READY timeout does not run here.
- FAULT:
  - ERROR=1 and FAB_RESET_N=0.
  - Only SW_RESTART_REQ exits: go to WAIT_LOCK, clear RETRY_COUNT and ERROR.
  - SW_RESTART_REQ is ignored in every other state.
- USER_RESET_N and USER_CLK_EN are 0 in every state except RUN.
- Lock loss (synchronised lock low for one cycle) in any of states 2–5 goes to WAIT_LOCK. It has priority over every other transition in the same cycle.
- Same-cycle ISP-high and MSS_READY-low in RUN: go to WAIT_READY.
- Debounce: the counter restarts on any raw level change. The flag takes a new level after ISP_DEBOUNCE_CYCLES stable cycles.
- Counter widths: $clog2(param+1). No wrap occurs, because each counter is cleared on state entry.

Optional Feature:
- Macro: ISP_SEQ_CAUSE_EN.
- When defined, adds output FAULT_CAUSE[1:0], sticky and reset to 0:
  - 01 = ready timeout caused FAULT.
  - 10 = lock lost while in RUN.
  - 11 = ISP_HOLD was exited.
- The latest event overwrites FAULT_CAUSE. It is cleared only by SW_RESTART_REQ or reset.
- When undefined, the port and its logic are absent. Sequencing is identical in both builds.

Decomposition:
- Shared package isp_seq_pkg holds:
  - state enum seq_state_t (3-bit encodings above);
  - cause enum fault_cause_t;
  - localparam SYNC_STAGES=2.
- One sub-module, isp_seq_sync_debounce: 2-flop synchroniser plus parameterised stable-count debounce.
  - Instanced for GPIO_3_M2F with debounce.
  - Instanced for the other status inputs with a debounce count of 0.

Test Plan:
Bench parameters: LOCK_FILTER_CYCLES=4, RESET_HOLD_CYCLES=8, READY_TIMEOUT_CYCLES=32, ISP_DEBOUNCE_CYCLES=3, MAX_RETRIES=2.
- Nominal: lock high at cycle 0, ready and init high at cycle 30 → FAB_RESET_N low for exactly 8 cycles; SEQ_STATE reaches 4; USER_RESET_N=1 one cycle after RUN entry.
- Glitchy lock: pattern 1,1,1,0,1,1,1,1 → ASSERT_FAB entered only after the final 4-high run.
- Timeouts: MSS_READY held low → 3 reset pulses, RETRY_COUNT 0→1→2, then FAULT with ERROR=1 and FAULT_CAUSE=01 (when enabled). SW_RESTART_REQ pulse → SEQ_STATE=1, ERROR=0.
- ISP: in RUN, GPIO_3_M2F high for 2 cycles → no change. High for 6 cycles → ISP_HOLD with USER_CLK_EN=0 and FAB_RESET_N=1. Flag low → ASSERT_FAB, then back to RUN.
- Priority: in RUN, drop lock and raise ISP in the same cycle → WAIT_LOCK.
- Async reset mid-WAIT_READY: POWER_ON_RESET_N low → all outputs return to reset values immediately, without waiting for a clock edge.
